// File: rtl/pipeline_pkg.sv
// Shared types and constants for the burst reader pipeline.
//   state_t        : burst framing FSM state (IDLE = beat 0, BURST = beats 1..BURST_LEN-1)
//   BURST_COUNT_W  : width of the completed-burst counter
package pipeline_pkg;

   localparam int unsigned BURST_COUNT_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/burst_reader_if.sv
// Output stream bundle of the burst reader.
//   m_data  : stream word
//   m_valid : qualifies m_data / m_last
//   m_ready : sink accepts the word when high with m_valid
//   m_last  : final word of a burst
interface burst_reader_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/burst_reader_skid.sv
// Two-entry output queue; the head entry is registered and drives the stream directly.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data this cycle (never while full without a pop)
//   push_data  : entry to enqueue
//   pop        : head consumed this cycle (only while valid)
//   head       : oldest entry
//   valid      : queue non-empty
//   count      : occupied entries (0..2)
module burst_reader_skid #(
   parameter int unsigned WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;

   // Queue state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Next-state: incoming words land in head when it is (or is becoming) free, else tail
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = push_data;
            else                 tail_d = push_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = push_data;
            end else begin
               head_d = tail_q;
               tail_d = push_data;
            end
         end
         default: ;
      endcase
   end

   assign head  = head_q;
   assign valid = (count_q != 2'd0);
   assign count = count_q;

endmodule

// File: rtl/burst_reader.sv
// Reads words from an upstream buffer (1-cycle read latency) and emits them as a
// ready/valid stream framed into bursts of BURST_LEN words, counting completed bursts.
//   clk, rst_n  : clock, async active-low reset
//   enable      : permits new buffer reads
//   buf_empty   : upstream buffer has no word
//   buf_data    : upstream read data, valid the cycle after read_en
//   read_en     : pop one upstream word (combinational: uses same-cycle credit)
//   burst_count : completed bursts, wraps at 16 bits
//   m           : output stream (m_data, m_valid, m_ready, m_last)
module burst_reader
   import pipeline_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_LEN  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     buf_empty,
   input  logic [DATA_WIDTH-1:0]    buf_data,
   output logic                     read_en,
   output logic [BURST_COUNT_W-1:0] burst_count,
   burst_reader_if.master           m
);

   localparam int unsigned BEAT_W    = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned QW        = DATA_WIDTH + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   state_t                   state_q, state_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic [BEAT_W-1:0]        push_beat_q, push_beat_d;
   logic [BURST_COUNT_W-1:0] burst_count_q, burst_count_d;
   logic                     inflight_q;

   logic [QW-1:0] q_head;
   logic          q_valid;
   logic [1:0]    q_count;
   logic          xfer;
   logic          push_last;
   logic [2:0]    occ_after;

   assign xfer = q_valid & m.m_ready;

   // Entries held or owed after this cycle's transfer; a read is allowed below 2
   assign occ_after = 3'(q_count) + 3'(inflight_q) - 3'(xfer);
   assign read_en   = rst_n & enable & ~buf_empty & (occ_after < 3'd2);

   // Words are tagged with their last flag as they enter the queue; order is preserved,
   // so the push-side position matches the transfer-side beat.
   assign push_last = (push_beat_q == LAST_BEAT);

   burst_reader_skid #(.WIDTH(QW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({push_last, buf_data}),
      .pop       (xfer),
      .head      (q_head),
      .valid     (q_valid),
      .count     (q_count)
   );

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         push_beat_q   <= '0;
         burst_count_q <= '0;
         inflight_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         push_beat_q   <= push_beat_d;
         burst_count_q <= burst_count_d;
         inflight_q    <= read_en;
      end
   end

   // Burst framing FSM; beats advance only on transfers
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      push_beat_d   = push_beat_q;
      burst_count_d = burst_count_q;

      if (inflight_q) push_beat_d = push_last ? '0 : push_beat_q + BEAT_W'(1);

      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d = BURST;
               beat_d  = BEAT_W'(1);
            end
         end
         BURST: begin
            if (xfer) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase

      if (xfer && m.m_last) burst_count_d = burst_count_q + BURST_COUNT_W'(1);
   end

   assign m.m_data    = q_head[DATA_WIDTH-1:0];
   assign m.m_last    = q_head[DATA_WIDTH] & q_valid;
   assign m.m_valid   = q_valid;
   assign burst_count = burst_count_q;

endmodule

// File: tb/tb_burst_reader.sv
// Scoreboard bench for burst_reader: stimulus loads an upstream buffer model and pushes
// the expected stream words; a monitor pops and compares on every transfer.
module tb_burst_reader;
   import pipeline_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned BL = 4;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     enable = 1'b0;
   logic                     buf_empty = 1'b1;
   logic [DW-1:0]            buf_data = '0;
   logic                     read_en;
   logic [BURST_COUNT_W-1:0] burst_count;

   burst_reader_if #(.DATA_WIDTH(DW)) bus ();

   burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .buf_empty   (buf_empty),
      .buf_data    (buf_data),
      .read_en     (read_en),
      .burst_count (burst_count),
      .m           (bus)
   );

   always #5 clk = ~clk;

   exp_t          exp_q[$];
   logic [DW-1:0] buf_q[$];
   int            vectors = 0;
   int            miscompares = 0;

   // Stimulus-side bookkeeping
   logic [DW-1:0] pending = '0;
   logic          pending_v = 1'b0;
   int            occ = 0;
   int            cyc, n_xfer, n_rd, first_xfer, last_xfer, first_rd, first_valid;
   logic [3:0]    rdy_pat = 4'b1001;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; n_xfer = 0; n_rd = 0;
      first_xfer = -1; last_xfer = -1; first_rd = -1; first_valid = -1;
   endtask

   task automatic load(input logic [DW-1:0] d, input logic last);
      buf_q.push_back(d);
      exp_q.push_back({last, d});
   endtask

   // One clock cycle: drive at negedge, sample DUT 1 time unit later
   task automatic step(input logic en, input logic rdy);
      logic s_rd, s_xfer;
      @(negedge clk);
      enable      = en;
      bus.m_ready = rdy;
      buf_data    = pending_v ? pending : 32'hDEAD_BEEF;
      pending_v   = 1'b0;
      buf_empty   = (buf_q.size() == 0);
      #1;
      s_xfer = bus.m_valid & rdy;
      s_rd   = read_en;
      if (s_rd) begin
         chk("read_while_empty", DW'(buf_empty), '0);
         chk("read_without_credit", DW'((occ - int'(s_xfer)) < 2), DW'(1));
         if (buf_q.size() > 0) begin
            pending   = buf_q.pop_front();
            pending_v = 1'b1;
         end
         n_rd++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      if (s_xfer) begin
         n_xfer++;
         if (first_xfer < 0) first_xfer = cyc;
         last_xfer = cyc;
      end
      occ = occ + int'(s_rd) - int'(s_xfer);
      cyc++;
   endtask

   // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1
   task automatic run(input logic en, input int mode, input int n);
      for (int i = 0; i < n; i++) step(en, (mode == 0) ? 1'b1 : rdy_pat[cyc % 4]);
   endtask

   // Reset for n cycles with enable high to show read_en is held low during reset
   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n       = 1'b0;
      enable      = 1'b1;
      buf_empty   = 1'b0;
      bus.m_ready = 1'b0;
      buf_q.delete();
      exp_q.delete();
      pending_v   = 1'b0;
      occ         = 0;
      repeat (n) @(negedge clk);
      enable    = 1'b0;
      buf_empty = 1'b1;
      rst_n     = 1'b1;
   endtask

   // Monitor: reset values, stall stability, and scoreboard compare on each transfer
   initial begin
      logic          stall;
      logic [DW-1:0] pd;
      logic          pl;
      exp_t          e;
      stall = 1'b0; pd = '0; pl = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            chk("rst_m_valid", DW'(bus.m_valid), '0);
            chk("rst_m_last", DW'(bus.m_last), '0);
            chk("rst_m_data", bus.m_data, '0);
            chk("rst_read_en", DW'(read_en), '0);
            chk("rst_burst_count", DW'(burst_count), '0);
            stall = 1'b0;
            continue;
         end
         if (stall) begin
            chk("stall_valid", DW'(bus.m_valid), DW'(1));
            chk("stall_data", bus.m_data, pd);
            chk("stall_last", DW'(bus.m_last), DW'(pl));
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got 0x%0h, want no transfer", bus.m_data);
            end else begin
               e = exp_q.pop_front();
               chk("data", bus.m_data, e.data);
               chk("last", DW'(bus.m_last), DW'(e.last));
            end
         end
         stall = bus.m_valid & ~bus.m_ready;
         pd    = bus.m_data;
         pl    = bus.m_last;
      end
   end

   initial begin
      bus.m_ready = 1'b0;
      clear_stats();
      do_reset(3);

      // Streaming: 8 words, two bursts, one word per cycle
      clear_stats();
      for (int i = 1; i <= 8; i++) load(DW'(i), (i % 4) == 0);
      run(1'b1, 0, 14);
      chk("stream_xfers", DW'(n_xfer), DW'(8));
      chk("stream_span", DW'(last_xfer - first_xfer), DW'(7));
      chk("stream_bcount", DW'(burst_count), DW'(2));
      chk("stream_drain", DW'(exp_q.size()), '0);

      // Backpressure: m_ready 1,0,0,1 over 12 words
      do_reset(2);
      clear_stats();
      for (int i = 0; i < 12; i++) load(DW'(32'h10 + i), (i % 4) == 3);
      run(1'b1, 1, 40);
      chk("bp_xfers", DW'(n_xfer), DW'(12));
      chk("bp_bcount", DW'(burst_count), DW'(3));
      chk("bp_drain", DW'(exp_q.size()), '0);

      // Empty edge: single word then empty
      do_reset(2);
      clear_stats();
      load(32'hA5, 1'b0);
      run(1'b1, 0, 8);
      chk("empty_reads", DW'(n_rd), DW'(1));
      chk("empty_latency", DW'(first_valid - first_rd), DW'(2));
      chk("empty_xfers", DW'(n_xfer), DW'(1));
      chk("empty_drain", DW'(exp_q.size()), '0);

      // Enable drop after the second read of a burst, then resume
      do_reset(2);
      clear_stats();
      for (int i = 1; i <= 8; i++) load(DW'(32'h30 + i), (i % 4) == 0);
      for (int i = 0; i < 10 && n_rd < 2; i++) step(1'b1, 1'b1);
      chk("drop_reads_issued", DW'(n_rd), DW'(2));
      run(1'b0, 0, 6);
      chk("drop_no_new_reads", DW'(n_rd), DW'(2));
      chk("drop_drained", DW'(n_xfer), DW'(2));
      chk("drop_bcount_mid", DW'(burst_count), '0);
      run(1'b1, 0, 14);
      chk("drop_xfers", DW'(n_xfer), DW'(8));
      chk("drop_bcount", DW'(burst_count), DW'(2));
      chk("drop_drain", DW'(exp_q.size()), '0);

      // Counter wrap: preset to 0xFFFF, one more burst wraps to 0
      do_reset(2);
      clear_stats();
      @(negedge clk);
      force dut.burst_count_q = 16'hFFFF;
      #1;
      release dut.burst_count_q;
      #1;
      chk("wrap_preset", DW'(burst_count), DW'(16'hFFFF));
      for (int i = 1; i <= 4; i++) load(DW'(32'h60 + i), i == 4);
      run(1'b1, 0, 10);
      chk("wrap_zero", DW'(burst_count), '0);
      chk("wrap_drain", DW'(exp_q.size()), '0);

      // Reset after beat 2: partial burst discarded, next burst framed from beat 1
      do_reset(2);
      clear_stats();
      for (int i = 1; i <= 8; i++) load(DW'(32'h40 + i), (i % 4) == 0);
      for (int i = 0; i < 12 && n_xfer < 2; i++) step(1'b1, 1'b1);
      chk("mid_beats_before_reset", DW'(n_xfer), DW'(2));
      do_reset(1);
      clear_stats();
      for (int i = 1; i <= 4; i++) load(DW'(32'h50 + i), i == 4);
      run(1'b1, 0, 10);
      chk("mid_xfers", DW'(n_xfer), DW'(4));
      chk("mid_bcount", DW'(burst_count), DW'(1));
      chk("mid_drain", DW'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/burst_reader.md
BURST_READER -- requirements
Module: burst_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width of the buffer read port and the output stream.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, range 2..256, meaning the number of words per output burst.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port enable, input, 1 bit, SHALL permit issue of new buffer reads while high.
REQ-006 Port buf_empty, input, 1 bit, SHALL indicate that the upstream buffer holds no word.
REQ-007 Port buf_data, input, DATA_WIDTH bits, SHALL carry upstream read data, valid exactly 1 cycle after read_en.
REQ-008 Port read_en, output, 1 bit, SHALL pop one word from the upstream buffer per high cycle.
REQ-009 Port m_data, output, DATA_WIDTH bits, SHALL carry the output stream word.
REQ-010 Port m_valid, output, 1 bit, SHALL qualify m_data and m_last.
REQ-011 Port m_ready, input, 1 bit, SHALL accept the output word when high with m_valid.
REQ-012 Port m_last, output, 1 bit, SHALL mark the final word of each burst.
REQ-013 Port burst_count, output, 16 bits, SHALL count completed bursts.

Function
REQ-014 A transfer SHALL occur on a cycle with m_valid and m_ready both high; m_data, m_last and m_valid SHALL stay stable while m_valid is high and m_ready is low.
REQ-015 The block SHALL hold a 2-entry output queue; the credit equals 2 minus (occupied entries plus in-flight reads).
REQ-016 read_en SHALL be asserted only when enable is high, buf_empty is low and the credit is at least 1 that cycle; credit freed by a same-cycle transfer SHALL count.
REQ-017 Sustained throughput SHALL be 1 word/cycle with m_ready held high and the buffer non-empty.
REQ-018 Latency SHALL be 2 cycles minimum: read_en at cycle N, m_valid at N+2 with that word.
REQ-019 The state machine SHALL have states IDLE (beat count 0) and BURST (beat count 1..BURST_LEN-1); the beat counter SHALL advance only on transfers.
REQ-020 m_last SHALL be high exactly on the transfer that makes the beat count equal BURST_LEN; that transfer SHALL return the state to IDLE with count 0.
REQ-021 burst_count SHALL increment on each m_last transfer and SHALL wrap from 0xFFFF to 0.
REQ-022 Deasserting enable mid-burst SHALL stop new reads only; in-flight and queued words SHALL still drain, and the burst SHALL resume on re-enable.
REQ-023 Word order SHALL be preserved; no word SHALL be dropped or duplicated under any m_ready pattern.
REQ-024 buf_empty high SHALL never coincide with read_en high.

Reset
REQ-025 While rst_n is low, read_en, m_valid, m_last, m_data and burst_count SHALL be 0, the state SHALL be IDLE, and the queue and in-flight tracking SHALL be empty.
REQ-026 Reset asserted mid-burst SHALL discard the partial burst and in-flight words; the first transfer after release SHALL be beat 1.

Structure
REQ-027 The FSM state enum and the burst_count width constant SHALL reside in shared package pipeline_pkg.
REQ-028 The 2-entry output queue SHALL be sub-module burst_reader_skid, parameterized by DATA_WIDTH plus 1 last bit.

Verification
REQ-029 Streaming: buffer preloaded with 8 words 0x1..0x8, m_ready=1, BURST_LEN=4 -> 8 transfers on consecutive cycles, m_last on 0x4 and 0x8, burst_count=2.
REQ-030 Backpressure: m_ready toggles 1,0,0,1 repeatedly over 12 words -> in-order data, m_data stable on stall cycles, read_en never high when credit is 0.
REQ-031 Empty edge: buffer holds 1 word, then goes empty -> exactly one read_en pulse, m_valid 2 cycles later, no read_en while buf_empty=1.
REQ-032 Enable drop: enable=0 after beat 2 of 4 -> queued words drain, no new reads; on re-enable, beats 3 and 4 follow with m_last on beat 4.
REQ-033 Counter wrap: burst_count forced to 0xFFFF via 65535 bursts (or fast-forward) -> next m_last transfer yields 0x0000.
REQ-034 Reset mid-burst: rst_n low for 1 cycle after beat 2 -> all outputs 0 immediately, and the next burst has m_last on its 4th transfer.
